vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Arbitrates the single-port tile/frame RAM between the VGA pixel fetch path and the processor's memory-mapped video writes and reads. The VGA stream has fixed priority with a bounded starvation guard for the CPU. The block sits between `vga_controller`, `processor` and the video RAM in the `Pacman` top level, on the `clock` domain.

## Interface
- `ADDR_W`, 12: RAM address width.
- `DATA_W`, 8: RAM data width.
- `STARVE_LIMIT`, 8: number of consecutive denied CPU cycles that forces a CPU grant. Range 1..255.

Ports:
- `clock`  in  1: single clock; all logic is rising-edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `vga_req`  in  1: VGA read request, sampled every cycle.
- `vga_addr`  in  ADDR_W: VGA read address.
- `vga_valid`  out  1: VGA read data valid.
- `vga_drop`  out  1: the VGA request issued 2 cycles earlier was dropped for the CPU.
- `vga_rdata`  out  DATA_W: VGA read data.
- `cpu_req`  in  1: CPU request; held, with `cpu_we`/`cpu_addr`/`cpu_wdata` stable, until `cpu_ack`.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_ack`  out  1: one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W: CPU read data, valid with `cpu_ack`.
- `ram_addr`  out  ADDR_W: RAM address (registered).
- `ram_we`  out  1: RAM write enable (registered).
- `ram_wdata`  out  DATA_W: RAM write data (registered).
- `ram_rdata`  in  DATA_W: RAM read data, valid 1 cycle after `ram_addr`.
- `stat_clr`  in  1: synchronous clear of statistics.
- `stat_vga_drops`  out  16: saturating count of VGA drops.
- `stat_cpu_grants`  out  16: saturating count of CPU grants.

## Operation
- Arbitration is combinational in cycle N on `vga_req`, `cpu_req` (considered only in `C_IDLE`) and `starve_cnt`.
- Grant rules:
  - If only VGA requests, VGA wins.
  - If only CPU requests, CPU wins.
  - If both request, VGA wins unless `starve_cnt == STARVE_LIMIT`, in which case CPU wins and the VGA request is dropped.
  - If neither requests, the slot is idle and `ram_we` is 0.
- CPU FSM:
  - `C_IDLE` → `C_ISSUE` on grant.
  - `C_ISSUE` → `C_ACK` unconditionally.
  - `C_ACK` → `C_IDLE` unconditionally; `cpu_ack` = 1 in this state.
  - `cpu_req` is ignored outside `C_IDLE`.
  - A new CPU request can therefore win no earlier than the cycle after the ack.
- `starve_cnt` (8 bits):
  - Increments when CPU is in `C_IDLE`, `cpu_req` = 1, and CPU is not granted.
  - Saturates at `STARVE_LIMIT`.
  - Clears on CPU grant, and when `cpu_req` = 0.
- VGA reads are fully pipelined: one issue per cycle, no back-pressure.
- Tag pipeline: 2 stages of {vga_rd, vga_drop, cpu_rd}.
- `vga_rdata` and `cpu_rdata` are wired directly to `ram_rdata`.

## Timing
- Reset values: all outputs 0, FSM in `C_IDLE`, `starve_cnt` 0, tag pipeline cleared.
- Arbitration in cycle N → `ram_addr`/`ram_we`/`ram_wdata` in N+1 → `ram_rdata` in N+2.
- VGA read latency: `vga_valid` = 1 in N+2, exactly 2 cycles after `vga_req`.
- Dropped VGA request: `vga_drop` = 1 in N+2 and `vga_valid` = 0.
- CPU latency: `cpu_ack` in N+2 for both reads and writes. The write is committed to RAM at the end of N+1.
- `vga_valid` and `vga_drop` are never both 1. `cpu_ack` and `vga_valid` are never both 1.
- Reset asserted mid-transaction: the pipeline is flushed and no ack or valid is emitted for in-flight requests. The CPU must re-request after reset.
- `STARVE_LIMIT` = 1: with continuous VGA traffic, the CPU is granted on its 2nd request cycle.

## Configuration
- `VRAM_ARB_STATS_EN` defined:
  - Two 16-bit saturating counters.
  - `stat_vga_drops` increments on each `vga_drop`.
  - `stat_cpu_grants` increments on each CPU grant.
  - `stat_clr` clears both, with priority over increment.
- `VRAM_ARB_STATS_EN` undefined: stat outputs are tied to 0, `stat_clr` is ignored, and no counter flops are built.

## Structure
- Package `vram_arb_pkg`:
  - CPU FSM state enum (`C_IDLE`, `C_ISSUE`, `C_ACK`).
  - Grant encoding enum (`G_NONE`, `G_VGA`, `G_CPU`).
  - Tag struct {vga_rd, vga_drop, cpu_rd}.
- One sub-module, `sat_counter16`, instantiated twice under the macro.

## Test plan
- VGA only: `vga_req` = 1 for 10 cycles at addr 0x000..0x009, RAM model returns addr[7:0] → `vga_valid` on cycles 2..11 with data 0x00..0x09, and `ram_we` stays 0.
- CPU write alone: addr 0x123, data 0xA5 → `ram_we` = 1 with 0x123/0xA5 one cycle after request, `cpu_ack` 2 cycles after; a subsequent read of 0x123 acks with `cpu_rdata` = 0xA5.
- Contention, `STARVE_LIMIT` = 3: `vga_req` continuous, `cpu_req` raised at cycle 0 → CPU granted at cycle 3, `vga_drop` = 1 at cycle 5, `cpu_ack` at cycle 5, `starve_cnt` back to 0.
- Back-to-back CPU requests: `cpu_req` held high continuously → grants exactly every 3 cycles, one `cpu_ack` per grant.
- Reset mid-flight: `resetn` = 0 for one cycle, 1 cycle after a CPU grant → no `cpu_ack`, all outputs 0, normal operation on next request.
- With `VRAM_ARB_STATS_EN` defined, contention scenario run for 100 cycles → `stat_vga_drops` equals `stat_cpu_grants` equals the number of `cpu_ack` pulses; `stat_clr` → both read 0 next cycle.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types for the video RAM arbiter: CPU FSM states, grant encoding, read-tag record.
package vram_arb_pkg;

  localparam int STARVE_W = 8;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_ISSUE = 2'd1,
    C_ACK   = 2'd2
  } cpu_state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VGA  = 2'd1,
    G_CPU  = 2'd2
  } grant_e;

  typedef struct packed {
    logic vga_rd;
    logic vga_drop;
    logic cpu_rd;
  } tag_t;

  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

endpackage

// File: rtl/vram_arbiter_sat_counter16.sv
// 16-bit saturating event counter with synchronous clear taking priority over increment.
module sat_counter16
  import vram_arb_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc)
      count_d = sat_inc(count_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: VGA fetch has fixed priority, CPU gets a starvation-bounded slot.
// Optional statistics counters are built only when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic              vga_drop,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              stat_clr,
  output logic [15:0]       stat_vga_drops,
  output logic [15:0]       stat_cpu_grants
);

  localparam logic [STARVE_W-1:0] LIMIT      = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = 1;

  cpu_state_e          cstate_q, cstate_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic                cpu_ack_q, cpu_ack_d;
  tag_t                tag1_q, tag1_d, tag2_q;
  grant_e              grant;
  logic                cpu_cand;

  always_comb begin
    cpu_cand = (cstate_q == C_IDLE) && cpu_req;
    grant    = G_NONE;
    if (vga_req && cpu_cand)
      grant = (starve_q == LIMIT) ? G_CPU : G_VGA;
    else if (vga_req)
      grant = G_VGA;
    else if (cpu_cand)
      grant = G_CPU;
  end

  always_comb begin
    cstate_d  = cstate_q;
    cpu_ack_d = 1'b0;
    case (cstate_q)
      C_IDLE:  if (grant == G_CPU) cstate_d = C_ISSUE;
      C_ISSUE: begin
        cstate_d  = C_ACK;
        cpu_ack_d = 1'b1;
      end
      C_ACK:   cstate_d = C_IDLE;
      default: cstate_d = C_IDLE;
    endcase

    // Counter holds while the CPU is mid-transaction with its request still up.
    starve_d = starve_q;
    if (!cpu_req || grant == G_CPU)
      starve_d = '0;
    else if (cstate_q == C_IDLE && starve_q != LIMIT)
      starve_d = starve_q + STARVE_ONE;

    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    case (grant)
      G_VGA: ram_addr_d = vga_addr;
      G_CPU: begin
        ram_addr_d  = cpu_addr;
        ram_wdata_d = cpu_wdata;
        ram_we_d    = cpu_we;
      end
      default: ;
    endcase

    tag1_d.vga_rd   = (grant == G_VGA);
    tag1_d.vga_drop = vga_req && (grant == G_CPU);
    tag1_d.cpu_rd   = (grant == G_CPU) && !cpu_we;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cstate_q    <= C_IDLE;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      cstate_q    <= cstate_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_ack_q   <= cpu_ack_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
    end
  end

  // A CPU read tag leaving the pipe must line up with the ack state.
  assert property (@(posedge clock) disable iff (!resetn) tag2_q.cpu_rd |-> cstate_q == C_ACK);

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign vga_valid = tag2_q.vga_rd;
  assign vga_drop  = tag2_q.vga_drop;
  assign cpu_ack   = cpu_ack_q;
  assign vga_rdata = ram_rdata;
  assign cpu_rdata = ram_rdata;

`ifdef VRAM_ARB_STATS_EN
  sat_counter16 u_drop_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (stat_clr),
    .inc    (tag2_q.vga_drop),
    .count  (stat_vga_drops)
  );

  sat_counter16 u_grant_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (stat_clr),
    .inc    (grant == G_CPU),
    .count  (stat_cpu_grants)
  );
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_vga_drops  = '0;
  assign stat_cpu_grants = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Table-driven bench for vram_arbiter with a registered-read RAM model, plus directed
// sequences for reset mid-flight, STARVE_LIMIT=1 and the optional statistics counters.
module tb_vram_arbiter;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  always #5 clock = ~clock;

  logic        vga_req = 1'b0;
  logic [11:0] vga_addr = '0;
  logic        vga_valid, vga_drop;
  logic [7:0]  vga_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_vga_drops, stat_cpu_grants;

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(3)) dut (
    .clock(clock), .resetn(resetn),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_drop(vga_drop),
    .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stat_clr(stat_clr), .stat_vga_drops(stat_vga_drops), .stat_cpu_grants(stat_cpu_grants)
  );

  // Second instance exercising the minimum starvation limit.
  logic        u1_vga_req = 1'b0, u1_cpu_req = 1'b0, u1_zero = 1'b0;
  logic [11:0] u1_addr = '0;
  logic [7:0]  u1_wdata = '0, u1_ram_rdata = '0;
  logic        u1_vga_valid, u1_vga_drop, u1_cpu_ack, u1_ram_we;
  logic [7:0]  u1_vga_rdata, u1_cpu_rdata, u1_ram_wdata;
  logic [11:0] u1_ram_addr;
  logic [15:0] u1_stat_drops, u1_stat_grants;

  vram_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(1)) dut_lim1 (
    .clock(clock), .resetn(resetn),
    .vga_req(u1_vga_req), .vga_addr(u1_addr), .vga_valid(u1_vga_valid), .vga_drop(u1_vga_drop),
    .vga_rdata(u1_vga_rdata),
    .cpu_req(u1_cpu_req), .cpu_we(u1_zero), .cpu_addr(u1_addr), .cpu_wdata(u1_wdata),
    .cpu_ack(u1_cpu_ack), .cpu_rdata(u1_cpu_rdata),
    .ram_addr(u1_ram_addr), .ram_we(u1_ram_we), .ram_wdata(u1_ram_wdata), .ram_rdata(u1_ram_rdata),
    .stat_clr(u1_zero), .stat_vga_drops(u1_stat_drops), .stat_cpu_grants(u1_stat_grants)
  );

  // RAM model: unwritten locations read back addr[7:0]; storage holds data XOR addr[7:0].
  bit [7:0] mem [0:4095];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata ^ ram_addr[7:0];
    ram_rdata <= mem[ram_addr] ^ ram_addr[7:0];
  end

  typedef struct {
    logic        vreq;
    logic [11:0] vaddr;
    logic        creq, cwe;
    logic [11:0] caddr;
    logic [7:0]  cwd;
    logic        e_vv, e_vd, e_ack, e_we;
    logic        chk_addr;
    logic [11:0] e_addr;
    logic [7:0]  e_wd;
    logic        chk_rd;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nmis = 0;
  int   acks = 0;

  task automatic add(input logic vreq, input logic [11:0] vaddr, input logic creq, input logic cwe,
                     input logic [11:0] caddr, input logic [7:0] cwd,
                     input logic evv, input logic evd, input logic eack, input logic ewe,
                     input logic ca, input logic [11:0] ea, input logic [7:0] ewd,
                     input logic cr, input logic [7:0] er);
    vec_t v;
    v.vreq = vreq; v.vaddr = vaddr; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.e_vv = evv; v.e_vd = evd; v.e_ack = eack; v.e_we = ewe;
    v.chk_addr = ca; v.e_addr = ea; v.e_wd = ewd; v.chk_rd = cr; v.e_rd = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] act, exp;

    // VGA only: addresses 0..9, data returns 0..9 two cycles later.
    for (int r = 0; r < 12; r++)
      add(r < 10, 12'(r), 1'b0, 1'b0, 12'h000, 8'h00,
          r >= 2, 1'b0, 1'b0, 1'b0,
          r >= 1, (r == 0) ? 12'h000 : ((r > 10) ? 12'h009 : 12'(r - 1)), 8'h00,
          r >= 2, 8'(r - 2));
    // CPU write 0x123 <- A5, then read it back.
    add(0, 12'h000, 1, 1, 12'h123, 8'hA5,  0, 0, 0, 0,  1, 12'h009, 8'h00, 0, 8'h00);
    add(0, 12'h000, 1, 1, 12'h123, 8'hA5,  0, 0, 0, 1,  1, 12'h123, 8'hA5, 0, 8'h00);
    add(0, 12'h000, 1, 1, 12'h123, 8'hA5,  0, 0, 1, 0,  1, 12'h123, 8'h00, 0, 8'h00);
    add(0, 12'h000, 1, 0, 12'h123, 8'h00,  0, 0, 0, 0,  1, 12'h123, 8'h00, 0, 8'h00);
    add(0, 12'h000, 1, 0, 12'h123, 8'h00,  0, 0, 0, 0,  1, 12'h123, 8'h00, 0, 8'h00);
    add(0, 12'h000, 1, 0, 12'h123, 8'h00,  0, 0, 1, 0,  1, 12'h123, 8'h00, 1, 8'hA5);
    add(0, 12'h000, 0, 0, 12'h000, 8'h00,  0, 0, 0, 0,  1, 12'h123, 8'h00, 0, 8'h00);
    // Contention, limit 3: CPU wins at c3, drop + ack at c5.
    add(1, 12'h040, 1, 0, 12'h123, 8'h00,  0, 0, 0, 0,  1, 12'h123, 8'h00, 0, 8'h00);
    add(1, 12'h041, 1, 0, 12'h123, 8'h00,  0, 0, 0, 0,  1, 12'h040, 8'h00, 0, 8'h00);
    add(1, 12'h042, 1, 0, 12'h123, 8'h00,  1, 0, 0, 0,  1, 12'h041, 8'h00, 1, 8'h40);
    add(1, 12'h043, 1, 0, 12'h123, 8'h00,  1, 0, 0, 0,  1, 12'h042, 8'h00, 1, 8'h41);
    add(1, 12'h044, 1, 0, 12'h123, 8'h00,  1, 0, 0, 0,  1, 12'h123, 8'h00, 1, 8'h42);
    add(1, 12'h045, 1, 0, 12'h123, 8'h00,  0, 1, 1, 0,  1, 12'h044, 8'h00, 1, 8'hA5);
    add(1, 12'h046, 0, 0, 12'h123, 8'h00,  1, 0, 0, 0,  1, 12'h045, 8'h00, 1, 8'h44);
    add(1, 12'h047, 0, 0, 12'h123, 8'h00,  1, 0, 0, 0,  1, 12'h046, 8'h00, 1, 8'h45);
    add(0, 12'h000, 0, 0, 12'h000, 8'h00,  1, 0, 0, 0,  1, 12'h047, 8'h00, 1, 8'h46);
    add(0, 12'h000, 0, 0, 12'h000, 8'h00,  1, 0, 0, 0,  1, 12'h047, 8'h00, 1, 8'h47);
    add(0, 12'h000, 0, 0, 12'h000, 8'h00,  0, 0, 0, 0,  1, 12'h047, 8'h00, 0, 8'h00);
    // Back-to-back CPU reads: acks every 3 cycles.
    for (int r = 0; r < 10; r++)
      add(1'b0, 12'h000, r <= 8, 1'b0, 12'h123, 8'h00,
          1'b0, 1'b0, (r == 2) || (r == 5) || (r == 8), 1'b0,
          1'b1, (r == 0) ? 12'h047 : 12'h123, 8'h00,
          (r == 2) || (r == 5) || (r == 8), 8'hA5);

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ctl", {28'd0, vga_valid, vga_drop, cpu_ack, ram_we}, 32'd0);
    chk("reset_ram", {12'd0, ram_addr, ram_wdata}, 32'd0);
    chk("reset_stats", {stat_vga_drops, stat_cpu_grants}, 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      vga_req = vecs[i].vreq;  vga_addr = vecs[i].vaddr;
      cpu_req = vecs[i].creq;  cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      act = {vga_valid, vga_drop, cpu_ack, ram_we,
             vecs[i].chk_addr ? ram_addr : 12'h000,
             vecs[i].e_we ? ram_wdata : 8'h00,
             vecs[i].chk_rd ? vga_rdata : 8'h00};
      exp = {vecs[i].e_vv, vecs[i].e_vd, vecs[i].e_ack, vecs[i].e_we,
             vecs[i].chk_addr ? vecs[i].e_addr : 12'h000,
             vecs[i].e_we ? vecs[i].e_wd : 8'h00,
             vecs[i].chk_rd ? vecs[i].e_rd : 8'h00};
      $display("vec %0d: vv=%b vd=%b ack=%b we=%b addr=%h rd=%h", i,
               vga_valid, vga_drop, cpu_ack, ram_we, ram_addr, vga_rdata);
      chk($sformatf("vec%0d", i), act, exp);
      if (vecs[i].chk_rd && vecs[i].e_ack) chk($sformatf("vec%0d_cpu_rdata", i), {24'd0, cpu_rdata}, {24'd0, vecs[i].e_rd});
      step();
    end

    // Reset one cycle after a CPU write grant: no ack, outputs cleared.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h5A;
    step();
    chk("rst_issue_we", {31'd0, ram_we}, 32'd1);
    resetn = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rst_outputs", {vga_valid, vga_drop, cpu_ack, ram_we, ram_addr, ram_wdata, 8'h00}, 32'd0);
    step();
    resetn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("rst_noack%0d", t), {30'd0, cpu_ack, vga_valid}, 32'd0);
      step();
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
    step();
    step();
    chk("rst_recover_ack", {23'd0, cpu_ack, cpu_rdata}, {23'd0, 1'b1, 8'hA5});
    cpu_req = 1'b0;
    step();

    // STARVE_LIMIT = 1: CPU granted on its second request cycle.
    u1_vga_req = 1'b1; u1_cpu_req = 1'b1;
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("lim1_t%0d", t), {29'd0, u1_cpu_ack, u1_vga_drop, u1_vga_valid},
          {29'd0, t == 3, t == 3, (t >= 2) && (t != 3)});
      if (t >= 3) u1_cpu_req = 1'b0;
      step();
    end
    u1_vga_req = 1'b0;

`ifdef VRAM_ARB_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stats_clr0", {stat_vga_drops, stat_cpu_grants}, 32'd0);
    vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
    for (int t = 0; t < 100; t++) begin
      if (cpu_ack) acks++;
      step();
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (cpu_ack) acks++;
      step();
    end
    chk("stats_acks", 32'(acks), 32'd17);
    chk("stats_drops", {16'd0, stat_vga_drops}, 32'(acks));
    chk("stats_grants", {16'd0, stat_cpu_grants}, 32'(acks));
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stats_clr1", {stat_vga_drops, stat_cpu_grants}, 32'd0);
`else
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stats_tied", {stat_vga_drops, stat_cpu_grants}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
